// File: rtl/bezier_lut_sequencer.sv
// Drives the quadratic-Bezier datapath across T and writes the 256-entry tone
// curve into the inactive half of a ping-pong LUT, swapping banks on VSYNC.
module bezier_lut_sequencer #(
    parameter int PIPE_LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [9:0]  CFG_P1,
    input  logic [9:0]  CFG_P2,
    input  logic        CFG_LOAD,
    input  logic        VSYNC,
    output logic [9:0]  BZ_P1,
    output logic [9:0]  BZ_P2,
    output logic [15:0] BZ_T,
    input  logic [7:0]  BZ_TT,
    output logic        LUT_WE,
    output logic        LUT_WBANK,
    output logic [7:0]  LUT_WADDR,
    output logic [7:0]  LUT_WDATA,
    output logic        ACTIVE_BANK,
    output logic        BUSY,
    output logic        DONE
);

    localparam int CW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [9:0]                  p1_q, p1_d;
    logic [9:0]                  p2_q, p2_d;
    logic [7:0]                  idx_q, idx_d;
    logic                        iss_vld_q, iss_vld_d;
    logic [PIPE_LAT-1:0]         pv_q, pv_d;
    logic [PIPE_LAT-1:0][7:0]    pidx_q, pidx_d;
    logic [CW-1:0]               drain_cnt_q, drain_cnt_d;
    logic                        active_q, active_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        vsync_q, vsync_d;
    logic                        vsync_rise_s;

    assign vsync_rise_s = VSYNC & ~vsync_q;

    // Next-state: sweep control, (valid,idx) alignment pipe and bank swap.
    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        idx_d       = idx_q;
        iss_vld_d   = iss_vld_q;
        drain_cnt_d = drain_cnt_q;
        active_d    = active_q;
        done_d      = 1'b0;
        vsync_d     = VSYNC;
        pv_d        = pv_q;
        pidx_d      = pidx_q;

        // Stage 0 captures the index currently presented on BZ_T.
        pv_d[0]   = iss_vld_q;
        pidx_d[0] = idx_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
        end

        if (CFG_LOAD) begin
            // Load always wins: stale in-flight samples are dropped this edge.
            p1_d        = CFG_P1;
            p2_d        = CFG_P2;
            idx_d       = 8'd0;
            iss_vld_d   = 1'b1;
            drain_cnt_d = '0;
            pv_d        = '0;
            state_d     = SWEEP;
        end else begin
            case (state_q)
                IDLE: begin
                    iss_vld_d = 1'b0;
                end
                SWEEP: begin
                    if (idx_q == 8'd255) begin
                        iss_vld_d   = 1'b0;
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == CW'(PIPE_LAT - 1)) begin
                        state_d = PEND;
                    end else begin
                        drain_cnt_d = drain_cnt_q + CW'(1);
                    end
                end
                PEND: begin
                    if (vsync_rise_s) begin
                        active_d = ~active_q;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    iss_vld_d = 1'b0;
                    pv_d      = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            p1_q        <= 10'd0;
            p2_q        <= 10'd0;
            idx_q       <= 8'd0;
            iss_vld_q   <= 1'b0;
            pv_q        <= '0;
            pidx_q      <= '0;
            drain_cnt_q <= '0;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            idx_q       <= idx_d;
            iss_vld_q   <= iss_vld_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
            drain_cnt_q <= drain_cnt_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vsync_q     <= vsync_d;
        end
    end

    assign BZ_P1       = p1_q;
    assign BZ_P2       = p2_q;
    assign BZ_T        = {idx_q, idx_q};
    assign LUT_WE      = pv_q[PIPE_LAT-1];
    assign LUT_WADDR   = pidx_q[PIPE_LAT-1];
    assign LUT_WDATA   = pv_q[PIPE_LAT-1] ? BZ_TT : 8'd0;
    assign LUT_WBANK   = ~active_q;
    assign ACTIVE_BANK = active_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;

endmodule

// File: tb/tb_bezier_lut_sequencer.sv
// Scoreboard bench for bezier_lut_sequencer with a 2-cycle Bezier datapath model.
module tb_bezier_lut_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [9:0]  CFG_P1 = 10'd0;
    logic [9:0]  CFG_P2 = 10'd0;
    logic        CFG_LOAD = 1'b0;
    logic        VSYNC = 1'b0;
    logic [9:0]  BZ_P1, BZ_P2;
    logic [15:0] BZ_T;
    logic [7:0]  BZ_TT;
    logic        LUT_WE, LUT_WBANK, ACTIVE_BANK, BUSY, DONE;
    logic [7:0]  LUT_WADDR, LUT_WDATA;

    typedef struct packed {
        logic       bank;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic [7:0] cap [2][256];
    logic [7:0] dp1 = 8'd0;
    logic [7:0] dp2 = 8'd0;

    always #5 CLK = ~CLK;

    bezier_lut_sequencer #(.PIPE_LAT(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CFG_P1(CFG_P1), .CFG_P2(CFG_P2),
        .CFG_LOAD(CFG_LOAD), .VSYNC(VSYNC), .BZ_P1(BZ_P1), .BZ_P2(BZ_P2),
        .BZ_T(BZ_T), .BZ_TT(BZ_TT), .LUT_WE(LUT_WE), .LUT_WBANK(LUT_WBANK),
        .LUT_WADDR(LUT_WADDR), .LUT_WDATA(LUT_WDATA), .ACTIVE_BANK(ACTIVE_BANK),
        .BUSY(BUSY), .DONE(DONE)
    );

    // B(t) = 2(1-t)t*P1 + t^2*P2 with P0=0, scaled by 1/2 and saturated to 8 bits.
    function automatic logic [7:0] bez(input logic [15:0] t16, input logic [9:0] p1,
                                       input logic [9:0] p2);
        logic [63:0] t, u, acc;
        t   = {48'd0, t16};
        u   = 64'd65536 - t;
        acc = ((64'd2 * u * t * {54'd0, p1}) + (t * t * {54'd0, p2})) >> 33;
        return (acc > 64'd255) ? 8'd255 : acc[7:0];
    endfunction

    // Datapath model: result appears two cycles after BZ_T.
    always @(posedge CLK) begin
        dp1 <= bez(BZ_T, BZ_P1, BZ_P2);
        dp2 <= dp1;
    end
    assign BZ_TT = dp2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected write per LUT_WE and counts DONE pulses.
    always @(negedge CLK) begin
        wr_t e;
        if (RESET_N) begin
            if (DONE) done_cnt++;
            if (LUT_WE) begin
                cap[LUT_WBANK][LUT_WADDR] = LUT_WDATA;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got bank %0d addr %0d, required no write",
                             LUT_WBANK, LUT_WADDR);
                end else begin
                    e = sb.pop_front();
                    check("lut_write", {15'd0, LUT_WBANK, LUT_WADDR, LUT_WDATA},
                          {15'd0, e.bank, e.addr, e.data});
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic bank, input logic [9:0] p1, input logic [9:0] p2,
                            input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = i[7:0];
            sb.push_back('{bank: bank, addr: a, data: bez({a, a}, p1, p2)});
        end
    endtask

    task automatic load(input logic [9:0] p1, input logic [9:0] p2);
        CFG_P1   = p1;
        CFG_P2   = p2;
        CFG_LOAD = 1'b1;
        tick();
        CFG_LOAD = 1'b0;
    endtask

    task automatic wait_idx(input logic [7:0] n);
        int k;
        for (k = 0; k < 400; k++) begin
            if (BUSY && BZ_T[15:8] == n) break;
            tick();
        end
        if (k == 400) check("wait_idx_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain(input logic chk_busy);
        int k;
        for (k = 0; k < 600; k++) begin
            if (sb.size() == 0) break;
            tick();
            if (chk_busy) check("busy_in_build", {31'd0, BUSY}, 32'd1);
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic vsync_swap(input logic exp_bank);
        int d0;
        d0 = done_cnt;
        VSYNC = 1'b1;
        tick();
        check("swap_done", {31'd0, DONE}, 32'd1);
        check("swap_active", {31'd0, ACTIVE_BANK}, {31'd0, exp_bank});
        check("swap_busy", {31'd0, BUSY}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, DONE}, 32'd0);
        VSYNC = 1'b0;
        check("done_count", done_cnt, d0 + 1);
    endtask

    initial begin
        int d0;
        // Reset values
        repeat (3) tick();
        check("rst_bz_t", {16'd0, BZ_T}, 32'd0);
        check("rst_we", {31'd0, LUT_WE}, 32'd0);
        check("rst_active", {31'd0, ACTIVE_BANK}, 32'd0);
        check("rst_busy_done", {30'd0, BUSY, DONE}, 32'd0);
        RESET_N = 1'b1;
        tick();

        // 1: reset mid-sweep; writes 0..48 precede it
        push_exp(1'b1, 10'd100, 10'd300, 49);
        load(10'd100, 10'd300);
        wait_idx(8'd50);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_outs", {BZ_T, 6'd0, BZ_P1}, 32'd0);
        check("mid_rst_lut", {15'd0, LUT_WE, LUT_WADDR, LUT_WDATA}, 32'd0);
        tick();
        check("mid_rst_ctrl", {29'd0, ACTIVE_BANK, BUSY, DONE}, 32'd0);
        check("mid_rst_sb", sb.size(), 32'd0);
        RESET_N = 1'b1;
        tick();

        // 2: full build P1=0, P2=512 into bank 1
        push_exp(1'b1, 10'd0, 10'd512, 256);
        load(10'd0, 10'd512);
        check("p2_shadow", {22'd0, BZ_P2}, 32'd512);
        wait_drain(1'b1);
        check("data0", {24'd0, cap[1][0]}, 32'd0);
        check("data128", {24'd0, cap[1][128]}, 32'd64);
        check("data255", {24'd0, cap[1][255]}, 32'd255);

        // 3: no swap while VSYNC low, then swap on rise
        d0 = done_cnt;
        repeat (1000) tick();
        check("pend_no_done", done_cnt, d0);
        check("pend_active", {30'd0, ACTIVE_BANK, BUSY}, 32'd1);
        vsync_swap(1'b1);

        // 4: abort at idx 100, rebuild bank 0 with new points
        push_exp(1'b0, 10'd200, 10'd700, 99);
        load(10'd200, 10'd700);
        wait_idx(8'd100);
        push_exp(1'b0, 10'd1023, 10'd100, 256);
        load(10'd1023, 10'd100);
        check("abort_stale", sb.size() <= 256, 32'd1);
        d0 = done_cnt;
        wait_drain(1'b1);
        repeat (5) tick();
        check("abort_no_done", done_cnt, d0);
        vsync_swap(1'b0);

        // 5: load and VSYNC rise in the same PEND cycle
        push_exp(1'b1, 10'd512, 10'd1023, 256);
        load(10'd512, 10'd1023);
        wait_drain(1'b1);
        repeat (3) tick();
        d0 = done_cnt;
        push_exp(1'b1, 10'd300, 10'd900, 256);
        VSYNC = 1'b1;
        load(10'd300, 10'd900);
        check("coll_done", {31'd0, DONE}, 32'd0);
        check("coll_active_busy", {30'd0, ACTIVE_BANK, BUSY}, 32'd1);
        VSYNC = 1'b0;

        // 6: VSYNC rise during sweep is ignored
        repeat (20) tick();
        VSYNC = 1'b1;
        repeat (2) tick();
        VSYNC = 1'b0;
        wait_drain(1'b1);
        repeat (5) tick();
        check("sweep_vsync_done", done_cnt, d0);
        check("sweep_vsync_active", {31'd0, ACTIVE_BANK}, 32'd0);
        vsync_swap(1'b1);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
